// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock sequencer.
//   - state_t       : controller phases
//   - STATUS_*      : 2-bit status codes driven to the status display
//   - DIGITS_DEF/DW_DEF : default code geometry (4 digits x 3 bits)
//   - max_int       : helper used to size the shared timer
package lock_pkg;

    localparam int DIGITS_DEF = 4;
    localparam int DW_DEF     = 3;

    typedef enum logic [2:0] {
        ST_UNSET   = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [1:0] STATUS_UNSET   = 2'b00;
    localparam logic [1:0] STATUS_ARMED   = 2'b01;
    localparam logic [1:0] STATUS_OPEN    = 2'b10;
    localparam logic [1:0] STATUS_LOCKOUT = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable, saturating down-counter shared by the OPEN and LOCKOUT phases.
// Ports:
//   clk        : system clock
//   srst       : synchronous active-high reset, clears the count
//   load       : load load_value this cycle (has priority over counting)
//   en         : decrement by one this cycle; holds at zero, never wraps
//   load_value : value taken on load
//   zero       : count is zero (decoded from the registered count)
module lock_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load,
    input  logic          en,
    input  logic [TW-1:0] load_value,
    output logic          zero
);

    logic [TW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Controller for the DIGITS x DW combination lock.
// Holds the stored code, the consecutive-failure counter and the shared
// open/lockout timer, and sequences UNSET -> ARMED -> CHECK -> OPEN/LOCKOUT.
// Ports:
//   CLK     : system clock
//   RST     : synchronous active-high reset, dominates all other inputs
//   S       : program request (one request per cycle while high)
//   CH      : check request
//   CODE_IN : entered digits, digit 0 in the low DW bits
//   STORED  : current stored code
//   STATUS  : 00 UNSET, 01 ARMED (also shown during CHECK), 10 OPEN, 11 LOCKOUT
//   UNLOCK  : high only in OPEN
//   FAILS   : consecutive failed checks, saturates at MAX_TRIES
//   BUSY    : high in CHECK and LOCKOUT
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int DIGITS      = DIGITS_DEF,
    parameter int DW          = DW_DEF,
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 S,
    input  logic                 CH,
    input  logic [DIGITS*DW-1:0] CODE_IN,
    output logic [DIGITS*DW-1:0] STORED,
    output logic [1:0]           STATUS,
    output logic                 UNLOCK,
    output logic [2:0]           FAILS,
    output logic                 BUSY
);

    // Timer holds at most max(OPEN_CYCLES, LOCK_CYCLES) - 1.
    localparam int            TMAX      = max_int(OPEN_CYCLES, LOCK_CYCLES);
    localparam int            TW        = $clog2(TMAX + 1);
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
    localparam logic [3:0]    MAX_W     = 4'(MAX_TRIES);

    state_t                 state_reg;
    logic [DIGITS*DW-1:0]   stored_reg;
    logic [DIGITS*DW-1:0]   compare_reg;
    logic [2:0]             fails_reg;

    logic                   timer_load;
    logic                   timer_en;
    logic [TW-1:0]          timer_value;
    logic                   timer_zero;

    logic [DIGITS-1:0]      digit_eq;
    logic                   code_match;
    logic [3:0]             fails_inc;

    // Compare the captured entry, never the live CODE_IN, so changes to the
    // keypad during CHECK cannot influence the result.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign digit_eq[gi] = (compare_reg[gi*DW +: DW] == stored_reg[gi*DW +: DW]);
    end
    assign code_match = &digit_eq;
    assign fails_inc  = {1'b0, fails_reg} + 4'd1;

    // Timer control: loaded on entry to OPEN/LOCKOUT and on re-program while
    // OPEN, otherwise counts down only while one of those phases is active.
    always_comb begin
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        timer_value = '0;
        case (state_reg)
            ST_CHECK: begin
                if (code_match) begin
                    timer_load  = 1'b1;
                    timer_value = OPEN_LOAD;
                end else if (fails_inc >= MAX_W) begin
                    timer_load  = 1'b1;
                    timer_value = LOCK_LOAD;
                end
            end
            ST_OPEN: begin
                if (S) begin
                    timer_load  = 1'b1;
                    timer_value = OPEN_LOAD;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_LOCKOUT: timer_en = 1'b1;
            default: ;
        endcase
    end

    lock_timer #(
        .TW(TW)
    ) u_timer (
        .clk        (CLK),
        .srst       (RST),
        .load       (timer_load),
        .en         (timer_en),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_UNSET;
            stored_reg  <= '0;
            compare_reg <= '0;
            fails_reg   <= '0;
        end else begin
            case (state_reg)
                ST_UNSET: begin
                    if (S) begin
                        stored_reg <= CODE_IN;
                        fails_reg  <= '0;
                        state_reg  <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // CH wins over S; S alone is ignored so a locked code
                    // cannot be overwritten.
                    if (CH) begin
                        compare_reg <= CODE_IN;
                        state_reg   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (code_match) begin
                        fails_reg <= '0;
                        state_reg <= ST_OPEN;
                    end else if (fails_inc < MAX_W) begin
                        fails_reg <= fails_inc[2:0];
                        state_reg <= ST_ARMED;
                    end else begin
                        fails_reg <= MAX_W[2:0];
                        state_reg <= ST_LOCKOUT;
                    end
                end
                ST_OPEN: begin
                    if (S) begin
                        stored_reg <= CODE_IN;
                    end else if (timer_zero) begin
                        state_reg <= ST_ARMED;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_zero) begin
                        fails_reg <= '0;
                        state_reg <= ST_ARMED;
                    end
                end
                default: state_reg <= ST_UNSET;
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        STATUS = STATUS_UNSET;
        UNLOCK = 1'b0;
        BUSY   = 1'b0;
        case (state_reg)
            ST_ARMED:   STATUS = STATUS_ARMED;
            ST_CHECK: begin
                STATUS = STATUS_ARMED;
                BUSY   = 1'b1;
            end
            ST_OPEN: begin
                STATUS = STATUS_OPEN;
                UNLOCK = 1'b1;
            end
            ST_LOCKOUT: begin
                STATUS = STATUS_LOCKOUT;
                BUSY   = 1'b1;
            end
            default: ;
        endcase
    end

    assign STORED = stored_reg;
    assign FAILS  = fails_reg;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: the driver applies one input vector per
// cycle and queues the hand-derived output snapshot expected after that edge;
// an independent monitor compares each queued snapshot on the falling edge.
module tb_lock_sequencer;

    localparam logic [1:0] U = 2'b00;
    localparam logic [1:0] A = 2'b01;
    localparam logic [1:0] O = 2'b10;
    localparam logic [1:0] L = 2'b11;

    logic        CLK;
    logic        RST;
    logic        S;
    logic        CH;
    logic [11:0] CODE_IN;
    logic [11:0] STORED;
    logic [1:0]  STATUS;
    logic        UNLOCK;
    logic [2:0]  FAILS;
    logic        BUSY;

    lock_sequencer dut (
        .CLK     (CLK),
        .RST     (RST),
        .S       (S),
        .CH      (CH),
        .CODE_IN (CODE_IN),
        .STORED  (STORED),
        .STATUS  (STATUS),
        .UNLOCK  (UNLOCK),
        .FAILS   (FAILS),
        .BUSY    (BUSY)
    );

    typedef struct packed {
        int          cyc;
        logic [1:0]  status;
        logic        unlock;
        logic [2:0]  fails;
        logic        busy;
        logic [11:0] stored;
    } exp_t;

    exp_t  sb[$];
    string nm_q[$];
    int    edge_cnt = 0;
    int    n_checks = 0;
    int    n_fail   = 0;

    // Digits written most-significant first: code(5,3,1,7) has digit 0 = 7.
    function automatic logic [11:0] code(input int d3, input int d2, input int d1, input int d0);
        return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    logic [11:0] C;
    logic [11:0] W;
    logic [11:0] P;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    // Monitor: pop every snapshot due at this edge count and compare.
    always @(negedge CLK) begin
        exp_t  e;
        string nm;
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            e  = sb.pop_front();
            nm = nm_q.pop_front();
            n_checks++;
            if (e.cyc != edge_cnt) begin
                n_fail++;
                $display("FAIL %s: snapshot for edge %0d seen at edge %0d", nm, e.cyc, edge_cnt);
            end else if ({STATUS, UNLOCK, FAILS, BUSY, STORED} !==
                         {e.status, e.unlock, e.fails, e.busy, e.stored}) begin
                n_fail++;
                $display("FAIL %s: got status=%b unlock=%b fails=%0d busy=%b stored=%h, expected status=%b unlock=%b fails=%0d busy=%b stored=%h",
                         nm, STATUS, UNLOCK, FAILS, BUSY, STORED,
                         e.status, e.unlock, e.fails, e.busy, e.stored);
            end else begin
                $display("edge %0d %s: status=%b unlock=%b fails=%0d busy=%b stored=%h ok",
                         edge_cnt, nm, STATUS, UNLOCK, FAILS, BUSY, STORED);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected outputs after the edge.
    task automatic step(input logic rst, input logic s, input logic ch, input logic [11:0] cin,
                        input logic [1:0] st, input logic [2:0] fl, input logic by,
                        input logic [11:0] sto, input string nm);
        exp_t e;
        RST     = rst;
        S       = s;
        CH      = ch;
        CODE_IN = cin;
        e.cyc    = edge_cnt + 1;
        e.status = st;
        e.unlock = (st == O);
        e.fails  = fl;
        e.busy   = by;
        e.stored = sto;
        sb.push_back(e);
        nm_q.push_back(nm);
        @(negedge CLK);
    endtask

    task automatic open_run(input int n, input logic [11:0] sto, input string nm);
        for (int i = 0; i < n; i++) step(0, 0, 0, W, O, 3'd0, 0, sto, nm);
    endtask

    task automatic lock_run(input int n, input logic [11:0] sto, input string nm);
        for (int i = 0; i < n; i++) step(0, 0, 0, W, L, 3'd3, 1, sto, nm);
    endtask

    initial begin
        C = code(5, 3, 1, 7);
        W = code(5, 3, 1, 6);
        P = code(0, 0, 0, 1);
        RST = 1'b1; S = 1'b0; CH = 1'b0; CODE_IN = '0;
        @(negedge CLK);

        // Reset, including RST dominating S/CH.
        step(1, 0, 0, C, U, 0, 0, 12'h000, "reset");
        step(1, 1, 1, C, U, 0, 0, 12'h000, "reset_dominates");

        // Program then correct check; CODE_IN changes during CHECK.
        step(0, 1, 0, C, A, 0, 0, C, "program");
        step(0, 1, 0, W, A, 0, 0, C, "armed_s_ignored");
        step(0, 0, 0, W, A, 0, 0, C, "armed_idle");
        step(0, 0, 1, C, A, 0, 1, C, "check_accept");
        step(0, 0, 0, W, O, 0, 0, C, "open_entry");
        step(0, 0, 1, W, O, 0, 0, C, "open_ch_ignored");
        open_run(6, C, "open_hold");
        step(0, 0, 0, W, A, 0, 0, C, "open_expired");

        // Wrong, wrong, correct.
        step(0, 0, 1, W, A, 0, 1, C, "wrong1_accept");
        step(0, 0, 0, W, A, 1, 0, C, "wrong1_result");
        step(0, 0, 1, W, A, 1, 1, C, "wrong2_accept");
        step(0, 0, 0, W, A, 2, 0, C, "wrong2_result");
        step(0, 0, 1, C, A, 2, 1, C, "right_accept");
        step(0, 0, 0, W, O, 0, 0, C, "right_after_two");
        open_run(7, C, "open_hold2");
        step(0, 0, 0, W, A, 0, 0, C, "open_expired2");

        // Lockout after three wrong checks, 16 cycles, inputs ignored.
        step(0, 0, 1, W, A, 0, 1, C, "lk_wrong1_accept");
        step(0, 0, 0, W, A, 1, 0, C, "lk_wrong1_result");
        step(0, 0, 1, W, A, 1, 1, C, "lk_wrong2_accept");
        step(0, 0, 0, W, A, 2, 0, C, "lk_wrong2_result");
        step(0, 0, 1, W, A, 2, 1, C, "lk_wrong3_accept");
        step(0, 0, 0, W, L, 3, 1, C, "lockout_entry");
        step(0, 0, 1, C, L, 3, 1, C, "lockout_ch_ignored");
        step(0, 1, 0, W, L, 3, 1, C, "lockout_s_ignored");
        lock_run(13, C, "lockout_hold");
        step(0, 0, 0, W, A, 0, 0, C, "lockout_exit");

        // S and CH together in ARMED: check happens, STORED unchanged.
        step(0, 1, 1, W, A, 0, 1, C, "armed_s_ch");
        step(0, 0, 0, W, A, 1, 0, C, "armed_s_ch_result");
        step(0, 0, 1, C, A, 1, 1, C, "reopen_accept");
        step(0, 0, 0, W, O, 0, 0, C, "reopen");
        open_run(2, C, "open_before_reprog");
        // S and CH together in OPEN: re-program and restart the open timer.
        step(0, 1, 1, P, O, 0, 0, P, "open_reprogram");
        open_run(7, P, "open_restarted");
        step(0, 0, 0, W, A, 0, 0, P, "open_restart_expired");

        // Reset while in CHECK.
        step(0, 0, 1, W, A, 0, 1, P, "pre_rst_accept");
        step(0, 0, 0, W, A, 1, 0, P, "pre_rst_result");
        step(0, 0, 1, W, A, 1, 1, P, "pre_rst_accept2");
        step(1, 0, 0, W, U, 0, 0, 12'h000, "rst_in_check");
        step(0, 0, 1, C, U, 0, 0, 12'h000, "unset_ch_ignored");
        step(0, 0, 0, C, U, 0, 0, 12'h000, "unset_idle");

        // Reset while in LOCKOUT.
        step(0, 1, 0, C, A, 0, 0, C, "reprogram");
        step(0, 0, 1, W, A, 0, 1, C, "rl_wrong1_accept");
        step(0, 0, 0, W, A, 1, 0, C, "rl_wrong1_result");
        step(0, 0, 1, W, A, 1, 1, C, "rl_wrong2_accept");
        step(0, 0, 0, W, A, 2, 0, C, "rl_wrong2_result");
        step(0, 0, 1, W, A, 2, 1, C, "rl_wrong3_accept");
        step(0, 0, 0, W, L, 3, 1, C, "rl_lockout_entry");
        lock_run(4, C, "rl_lockout_hold");
        step(1, 0, 0, W, U, 0, 0, 12'h000, "rst_in_lockout");
        step(0, 0, 1, C, U, 0, 0, 12'h000, "unset_ch_ignored2");

        // Let the monitor drain, then confirm nothing was left unchecked.
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d snapshots left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
